// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush controller
// Arbitrates MEM redirects, multi-cycle EX sequencing with timeout, and load-use stalls.
module pipe_ctrl #(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 7,
   parameter int PERF_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_id,
   input  logic              ex_mc_start,
   input  logic              ex_mc_done,
   input  logic              mem_redirect_valid,
   input  logic [31:0]       mem_redirect_pc,
   output logic [4:0]        stall,
   output logic              flush,
   output logic              new_pc_valid,
   output logic [31:0]       new_pc,
   output logic              mc_cancel,
   output logic              mc_timeout,
   output logic              busy,
   output logic [PERF_W-1:0] stall_cycles
);

   typedef enum logic {
      IDLE    = 1'b0,
      MC_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] STALL_NONE = 5'b00000;
   localparam logic [4:0] STALL_LU   = 5'b00011;
   localparam logic [4:0] STALL_MC   = 5'b00111;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         stall_cycles <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if ((stall != STALL_NONE) && (stall_cycles != {PERF_W{1'b1}}))
            stall_cycles <= stall_cycles + PERF_W'(1);
      end
   end

   // Priority within a cycle: redirect, then multi-cycle, then load-use.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      stall        = STALL_NONE;
      flush        = 1'b0;
      new_pc_valid = 1'b0;
      new_pc       = 32'h0;
      mc_cancel    = 1'b0;
      mc_timeout   = 1'b0;
      busy         = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (mem_redirect_valid) begin
                  flush        = 1'b1;
                  new_pc_valid = 1'b1;
                  new_pc       = mem_redirect_pc;
                  mc_cancel    = ex_mc_start;
               end else if (ex_mc_start) begin
                  stall      = STALL_MC;
                  cnt_next   = CNT_W'(1);
                  state_next = MC_WAIT;
               end else if (stallreq_id) begin
                  stall = STALL_LU;
               end
            end
            MC_WAIT: begin
               busy = 1'b1;
               if (mem_redirect_valid) begin
                  flush        = 1'b1;
                  new_pc_valid = 1'b1;
                  new_pc       = mem_redirect_pc;
                  mc_cancel    = 1'b1;
                  state_next   = IDLE;
                  cnt_next     = '0;
               end else if (ex_mc_done) begin
                  // Result advances into EX/MEM this cycle, so no hold.
                  state_next = IDLE;
                  cnt_next   = '0;
               end else if (cnt == CNT_W'(MC_TIMEOUT)) begin
                  mc_timeout = 1'b1;
                  mc_cancel  = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  stall    = STALL_MC;
                  cnt_next = cnt + CNT_W'(1);
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
// Inputs change 1ns after posedge; combinational outputs are checked 4ns later.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id;
   logic        ex_mc_start;
   logic        ex_mc_done;
   logic        mem_redirect_valid;
   logic [31:0] mem_redirect_pc;
   logic [4:0]  stall;
   logic        flush;
   logic        new_pc_valid;
   logic [31:0] new_pc;
   logic        mc_cancel;
   logic        mc_timeout;
   logic        busy;
   logic [31:0] stall_cycles;

   int n_cmp = 0;
   int n_err = 0;

   pipe_ctrl #(.MC_TIMEOUT(64), .CNT_W(7), .PERF_W(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .stallreq_id        (stallreq_id),
      .ex_mc_start        (ex_mc_start),
      .ex_mc_done         (ex_mc_done),
      .mem_redirect_valid (mem_redirect_valid),
      .mem_redirect_pc    (mem_redirect_pc),
      .stall              (stall),
      .flush              (flush),
      .new_pc_valid       (new_pc_valid),
      .new_pc             (new_pc),
      .mc_cancel          (mc_cancel),
      .mc_timeout         (mc_timeout),
      .busy               (busy),
      .stall_cycles       (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic sr, input logic st, input logic dn, input logic rv,
                        input logic [31:0] pc);
      stallreq_id        = sr;
      ex_mc_start        = st;
      ex_mc_done         = dn;
      mem_redirect_valid = rv;
      mem_redirect_pc    = pc;
      #4;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic [4:0] e_stall, input logic e_flush,
                           input logic e_npv, input logic [31:0] e_pc, input logic e_cancel,
                           input logic e_tmo, input logic e_busy);
      chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
      chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
      chk({tag, ".new_pc_valid"}, 32'(new_pc_valid), 32'(e_npv));
      chk({tag, ".new_pc"}, new_pc, e_pc);
      chk({tag, ".mc_cancel"}, 32'(mc_cancel), 32'(e_cancel));
      chk({tag, ".mc_timeout"}, 32'(mc_timeout), 32'(e_tmo));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();

      // Reset masks every input.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hABCD_0000);
      chk_outs("reset", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("reset.stall_cycles", stall_cycles, 32'd0);

      // Idle 5 cycles.
      for (int i = 0; i < 5; i++) begin
         chk_outs("idle", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         tick();
         drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      end
      chk("idle.stall_cycles", stall_cycles, 32'd0);

      // Load-use for 2 cycles.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
         chk_outs("loaduse", 5'b00011, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("loaduse.stall_cycles", stall_cycles, 32'd2);

      // Multi-cycle op, done 10 cycles after start; stallreq_id ignored while busy.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk_outs("mc_start", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 9; i++) begin
         drive((i == 3), 1'b0, 1'b0, 1'b0, 32'h0);
         chk_outs("mc_wait", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
         tick();
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk_outs("mc_done", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk_outs("done_in_idle", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("mc_done.stall_cycles", stall_cycles, 32'd12);
      tick();

      // Timeout: 64 stalled cycles, then one cancel/timeout cycle.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk_outs("tmo_start", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 63; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         chk("tmo_wait.stall", 32'(stall), 32'h07);
         chk("tmo_wait.mc_timeout", 32'(mc_timeout), 32'h0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_outs("tmo_fire", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_outs("tmo_after", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("tmo.stall_cycles", stall_cycles, 32'd76);

      // Redirect in MC_WAIT with simultaneous done.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("redir_wait.busy", 32'(busy), 32'h1);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h1C00_8000);
      chk_outs("redir_mc", 5'b00000, 1'b1, 1'b1, 32'h1C00_8000, 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h1C00_8000);
      chk_outs("redir_after", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("redir.stall_cycles", stall_cycles, 32'd78);

      // Redirect + start + load-use in IDLE: cancel, stay IDLE.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5678);
      chk_outs("redir_idle", 5'b00000, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
      tick();
      // Back-to-back redirects each flush.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
      chk_outs("b2b_1", 5'b00000, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
      chk_outs("b2b_2", 5'b00000, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
      tick();

      // Start + load-use only: enter MC_WAIT.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk_outs("start_lu", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_outs("start_lu_wait", 5'b00111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("start_lu.stall_cycles", stall_cycles, 32'd80);

      // Reset mid MC_WAIT: no cancel pulse, back to IDLE.
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_outs("rst_mid", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_outs("rst_after", 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("rst_after.stall_cycles", stall_cycles, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the five-stage scalar core. Generates per-stage stall and global flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Sequences multi-cycle EX operations (div/mul) and enforces a timeout on them. Arbitrates between load-use stalls, multi-cycle stalls and MEM-stage redirects (exception, ertn), and drives the fetch redirect PC.

Parameters:
MC_TIMEOUT, 64, maximum MC_WAIT cycles before a multi-cycle op is forcibly cancelled
CNT_W, 7, width of multi-cycle cycle counter; must hold MC_TIMEOUT
PERF_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallreq_id  in  1  load-use hazard detected in ID
ex_mc_start  in  1  multi-cycle op entering EX this cycle (1-cycle pulse)
ex_mc_done  in  1  multi-cycle unit result ready (1-cycle pulse)
mem_redirect_valid  in  1  exception/ertn taken in MEM
mem_redirect_pc  in  32  target PC (eentry or era)
stall  out  5  [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb hold
flush  out  1  clear all pipeline registers to bubble
new_pc_valid  out  1  fetch must load new_pc
new_pc  out  32  redirect target
mc_cancel  out  1  abort multi-cycle unit
mc_timeout  out  1  multi-cycle op exceeded MC_TIMEOUT
busy  out  1  state == MC_WAIT
stall_cycles  out  PERF_W  count of cycles with stall != 0

Behaviour:
- All control outputs are combinational from state, counter and current-cycle inputs. state, counter and stall_cycles are registered.
- Stall encoding: stall[k]=1 and stall[k+1]=0 means stage k+1 receives a bubble. Legal values are 00000, 00011 and 00111 only.
- While rst is high: outputs stall=0, flush=0, new_pc_valid=0, new_pc=0, mc_cancel=0, mc_timeout=0, busy=0. Registered state: state=IDLE, cnt=0, stall_cycles=0.
- FSM states: IDLE, MC_WAIT.
- Priority within a cycle: redirect > multi-cycle > load-use.
- IDLE:
  - mem_redirect_valid: flush=1, new_pc_valid=1, new_pc=mem_redirect_pc, stall=0. If ex_mc_start is also high, mc_cancel=1 and the FSM stays in IDLE.
  - else ex_mc_start: stall=00111, cnt<=1, next state MC_WAIT. A simultaneous stallreq_id is subsumed.
  - else stallreq_id: stall=00011.
  - else stall=0.
- MC_WAIT (busy=1):
  - mem_redirect_valid: flush=1, new_pc_valid=1, new_pc=mem_redirect_pc, mc_cancel=1, stall=0, next state IDLE. A simultaneous ex_mc_done is discarded.
  - else ex_mc_done: stall=0 (the result advances into EX/MEM this cycle), next state IDLE, cnt<=0.
  - else cnt==MC_TIMEOUT: mc_timeout=1, mc_cancel=1, stall=0, next state IDLE, cnt<=0.
  - else stall=00111, cnt<=cnt+1.
  - ex_mc_start and stallreq_id are ignored in MC_WAIT.
- new_pc is 0 whenever new_pc_valid=0.
- flush is a single-cycle pulse per redirect. Back-to-back redirects each produce a flush pulse.
- stall_cycles increments each cycle stall!=0 (rst low) and saturates at all-ones. It is cleared only by rst.
- ex_mc_done in IDLE is ignored (no output effect).
- rst asserted mid-MC_WAIT returns the FSM to IDLE next cycle with no mc_cancel pulse; the multi-cycle unit is reset by the same rst.

Test Plan:
- Reset then idle for 5 cycles -> all outputs 0, stall_cycles=0.
- stallreq_id high for 2 cycles in IDLE -> stall=00011 both cycles, stall_cycles=2.
- ex_mc_start, ex_mc_done 10 cycles later -> busy and stall=00111 for 10 cycles, stall=0 on the done cycle, state IDLE after.
- ex_mc_start with no done -> after MC_TIMEOUT=64 stalled cycles, one cycle of mc_timeout=1 and mc_cancel=1, then IDLE.
- In MC_WAIT, mem_redirect_valid=1 with mem_redirect_pc=0x1C008000 and ex_mc_done=1 -> flush=1, new_pc_valid=1, new_pc=0x1C008000, mc_cancel=1, stall=0, then IDLE.
- Same-cycle ex_mc_start, stallreq_id and mem_redirect_valid in IDLE -> flush=1, mc_cancel=1, stall=0, FSM stays IDLE. Same-cycle ex_mc_start and stallreq_id only -> stall=00111, FSM enters MC_WAIT.
